// File: rtl/wb_trace.sv
// Register-file write tracer: every write is captured into a FIFO and
// drained high byte first over a byte-wide valid/ready stream.
module wb_trace #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [15:0]   wd,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic [AW:0]   fifo_cnt,
    output logic          ovf,
    output logic [7:0]    drop_cnt,
    input  logic          clr_ovf
);

    typedef enum logic [1:0] {IDLE, HI, LO} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [15:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_cnt;
    logic [15:0]     r_word;
    logic            r_ovf;
    logic [7:0]      r_drop_cnt;

    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic            w_nonempty;
    logic            w_full;

    assign w_nonempty = (r_cnt != '0);
    assign w_full     = (r_cnt == (AW+1)'(DEPTH));
    // A pop in the same cycle frees the slot the incoming write needs.
    assign w_push     = we && (!w_full || w_pop);
    assign w_drop     = we && !w_push;

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        case (r_state)
            IDLE: begin
                if (w_nonempty) begin
                    w_pop        = 1'b1;
                    w_state_next = HI;
                end
            end
            HI: begin
                tx_valid = 1'b1;
                tx_data  = r_word[15:8];
                if (tx_ready) begin
                    w_state_next = LO;
                end
            end
            LO: begin
                tx_valid = 1'b1;
                tx_data  = r_word[7:0];
                if (tx_ready) begin
                    if (w_nonempty) begin
                        w_pop        = 1'b1;
                        w_state_next = HI;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Storage array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_word     <= 16'h0000;
        end else begin
            r_state <= w_state_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_word   <= r_mem[r_rd_ptr];
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // A drop in the same cycle as a clear restarts the count at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= 8'h00;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (clr_ovf) begin
                r_drop_cnt <= 8'h01;
            end else if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'h01;
            end
        end else if (clr_ovf) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= 8'h00;
        end
    end

    assign fifo_cnt = r_cnt;
    assign ovf      = r_ovf;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_wb_trace.sv
// Directed self-checking bench for wb_trace: latency, back-to-back drain,
// backpressure, overflow/saturation, full-with-pop and reset mid-transfer.
module tb_wb_trace;

    logic        clk;
    logic        rst;
    logic        we;
    logic [15:0] wd;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  fifo_cnt;
    logic        ovf;
    logic [7:0]  drop_cnt;
    logic        clr_ovf;

    int vectors;
    int miscompares;

    wb_trace #(.DEPTH(8), .AW(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .wd       (wd),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .fifo_cnt (fifo_cnt),
        .ovf      (ovf),
        .drop_cnt (drop_cnt),
        .clr_ovf  (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_byte(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, {15'd0, tx_valid}, 16'd1);
        chk({tag, "_data"}, {8'd0, tx_data}, {8'd0, exp});
    endtask

    initial begin
        logic [15:0] exp_words [9];
        vectors     = 0;
        miscompares = 0;
        rst      = 1'b1;
        we       = 1'b0;
        wd       = 16'h0000;
        tx_ready = 1'b0;
        clr_ovf  = 1'b0;
        #1;
        step();
        step();
        rst = 1'b0;
        chk("rst_valid", {15'd0, tx_valid}, 16'd0);
        chk("rst_data", {8'd0, tx_data}, 16'd0);
        chk("rst_cnt", {12'd0, fifo_cnt}, 16'd0);
        chk("rst_ovf", {15'd0, ovf}, 16'd0);
        chk("rst_drop", {8'd0, drop_cnt}, 16'd0);

        // Single word, minimum latency
        tx_ready = 1'b1;
        we = 1'b1; wd = 16'hA55A;
        step();
        we = 1'b0;
        chk("lat_cnt1", {12'd0, fifo_cnt}, 16'd1);
        chk("lat_novalid", {15'd0, tx_valid}, 16'd0);
        step();
        chk_byte("lat_hi", 8'hA5);
        chk("lat_cnt0", {12'd0, fifo_cnt}, 16'd0);
        step();
        chk_byte("lat_lo", 8'h5A);
        step();
        chk("lat_idle", {15'd0, tx_valid}, 16'd0);
        chk("lat_ovf", {15'd0, ovf}, 16'd0);

        // Three consecutive captures, gapless stream
        we = 1'b1; wd = 16'h0001;
        step();
        chk("b2b_wait", {15'd0, tx_valid}, 16'd0);
        wd = 16'h0002;
        step();
        chk_byte("b2b_b0", 8'h00);
        wd = 16'h0003;
        step();
        we = 1'b0;
        chk_byte("b2b_b1", 8'h01);
        step(); chk_byte("b2b_b2", 8'h00);
        step(); chk_byte("b2b_b3", 8'h02);
        step(); chk_byte("b2b_b4", 8'h00);
        step(); chk_byte("b2b_b5", 8'h03);
        step();
        chk("b2b_idle", {15'd0, tx_valid}, 16'd0);

        // Backpressure while in HI
        tx_ready = 1'b0;
        we = 1'b1; wd = 16'h1234;
        step();
        we = 1'b0;
        step();
        chk_byte("bp_hi", 8'h12);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_byte("bp_hold", 8'h12);
        end
        tx_ready = 1'b1;
        step();
        chk_byte("bp_lo", 8'h34);
        step();
        chk("bp_idle", {15'd0, tx_valid}, 16'd0);

        // Overflow: 11 captures against a stalled sink
        tx_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            we = 1'b1; wd = 16'(i);
            step();
        end
        we = 1'b0;
        chk("ovf_cnt", {12'd0, fifo_cnt}, 16'd8);
        chk("ovf_flag", {15'd0, ovf}, 16'd1);
        chk("ovf_drop", {8'd0, drop_cnt}, 16'd2);
        chk_byte("ovf_w0hi", 8'h00);

        // Move serializer to LO with FIFO still full, then push+pop together
        tx_ready = 1'b1;
        step();
        chk_byte("full_w0lo", 8'h00);
        chk("full_cnt_lo", {12'd0, fifo_cnt}, 16'd8);
        we = 1'b1; wd = 16'h00AA;
        step();
        we = 1'b0;
        chk("full_pp_cnt", {12'd0, fifo_cnt}, 16'd8);
        chk("full_pp_drop", {8'd0, drop_cnt}, 16'd2);
        for (int i = 0; i < 8; i++) exp_words[i] = 16'(i + 1);
        exp_words[8] = 16'h00AA;
        for (int i = 0; i < 9; i++) begin
            chk_byte($sformatf("drain%0d_hi", i), exp_words[i][15:8]);
            step();
            chk_byte($sformatf("drain%0d_lo", i), exp_words[i][7:0]);
            step();
        end
        chk("drain_idle", {15'd0, tx_valid}, 16'd0);
        chk("drain_cnt", {12'd0, fifo_cnt}, 16'd0);

        // Clear, then saturate the drop counter
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("clr_ovf", {15'd0, ovf}, 16'd0);
        chk("clr_drop", {8'd0, drop_cnt}, 16'd0);
        tx_ready = 1'b0;
        we = 1'b1; wd = 16'h7777;
        for (int i = 0; i < 9; i++) step();
        chk("sat_fill_cnt", {12'd0, fifo_cnt}, 16'd8);
        chk("sat_fill_drop", {8'd0, drop_cnt}, 16'd0);
        for (int i = 0; i < 300; i++) step();
        chk("sat_drop", {8'd0, drop_cnt}, 16'd255);
        chk("sat_ovf", {15'd0, ovf}, 16'd1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        we = 1'b0;
        chk("clrdrop_ovf", {15'd0, ovf}, 16'd1);
        chk("clrdrop_cnt", {8'd0, drop_cnt}, 16'd1);

        // Reset while in LO with four words queued
        rst = 1'b1;
        step();
        rst = 1'b0;
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            we = 1'b1; wd = 16'h1100 + 16'(i);
            step();
        end
        we = 1'b0;
        tx_ready = 1'b1;
        step();
        chk_byte("mid_lo", 8'h00);
        chk("mid_cnt", {12'd0, fifo_cnt}, 16'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", {15'd0, tx_valid}, 16'd0);
        chk("mid_rst_cnt", {12'd0, fifo_cnt}, 16'd0);
        chk("mid_rst_drop", {8'd0, drop_cnt}, 16'd0);
        we = 1'b1; wd = 16'hBEEF;
        step();
        we = 1'b0;
        step();
        chk_byte("beef_hi", 8'hBE);
        step();
        chk_byte("beef_lo", 8'hEF);
        step();
        chk("beef_idle", {15'd0, tx_valid}, 16'd0);
        step();
        chk("beef_stay_idle", {15'd0, tx_valid}, 16'd0);
        chk("beef_cnt", {12'd0, fifo_cnt}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_trace.md
Name: wb_trace

Overview:
- Downstream observer of the processing unit's register-file write port.
- Every write the unit performs (we=1 with value wd) is captured into a small FIFO.
- Captured words are drained MSB-byte-first over a byte-wide valid/ready stream to a host link, e.g. a UART transmitter or test harness.
- Dropped captures are counted and flagged, so the host can tell the trace is incomplete.

Parameters:
- DEPTH, 8: FIFO depth in 16-bit words; must be a power of two, at least 2.
- AW, 3: log2(DEPTH); pointer width.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst, input, 1: synchronous, active-high reset.
- we, input, 1: write strobe from the processing unit; one capture per cycle high.
- wd, input, 16: write data from the processing unit; sampled when we=1.
- tx_data, output, 8: byte currently offered to the sink.
- tx_valid, output, 1: tx_data is valid.
- tx_ready, input, 1: sink accepts the byte; a transfer occurs when tx_valid & tx_ready.
- fifo_cnt, output, AW+1: words held in the FIFO (0..DEPTH), excluding the word in the serializer.
- ovf, output, 1: sticky flag; at least one capture was dropped since reset or clear.
- drop_cnt, output, 8: dropped captures, saturating at 255.
- clr_ovf, input, 1: clears ovf and drop_cnt.

Behaviour:
- Reset (rst=1 at an edge):
  - fifo_cnt=0, read/write pointers=0.
  - State=IDLE, tx_valid=0, tx_data=0, ovf=0, drop_cnt=0.
  - Reset overrides all other inputs in that cycle.
  - Reset mid-transfer discards any partially sent word and all FIFO contents.
- Capture:
  - When we=1, wd is written at the write pointer if there is space, and the pointer wraps modulo DEPTH.
  - Space exists if fifo_cnt<DEPTH or a pop occurs in the same cycle.
  - With fifo_cnt=DEPTH and a simultaneous pop, the capture is accepted and fifo_cnt stays DEPTH.
- Drop:
  - When we=1 with no space, wd is discarded, ovf<=1, and drop_cnt<=drop_cnt+1 (holds at 255).
  - If clr_ovf=1 in the same cycle as a drop, the drop wins: ovf=1, drop_cnt=1.
  - If clr_ovf=1 with no drop, ovf<=0 and drop_cnt<=0.
- fifo_cnt update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Serializer state machine:
  - Holds a 16-bit word register W and has states IDLE, HI, LO.
  - IDLE: tx_valid=0. If fifo_cnt>0, pop the head into W and go to HI.
  - HI: tx_valid=1, tx_data=W[15:8]. On tx_ready, go to LO.
  - LO: tx_valid=1, tx_data=W[7:0]. On tx_ready: if fifo_cnt>0, pop into W and go to HI (back-to-back, no idle bubble); otherwise go to IDLE.
  - While tx_valid=1 and tx_ready=0, tx_data and state hold stable.
  - tx_valid never drops without a transfer.
- Latency:
  - Capture at edge N (we=1 in cycle N-1) makes the FIFO non-empty in cycle N.
  - The pop happens at edge N+1; tx_valid=1 with the high byte in cycle N+1.
  - Minimum we-to-first-byte latency is 2 cycles. There is no FIFO bypass.
- Throughput:
  - Steady-state drain is 1 word per 2 cycles with tx_ready held at 1.
  - A sustained we every cycle therefore overflows after the FIFO fills.
- Ordering: words leave in capture order. Bytes go high byte then low byte, with no reordering across wrap-around.

Test Plan:
- Reset, then we=1, wd=16'hA55A for one cycle with tx_ready=1 -> two cycles later tx_data=8'hA5 (tx_valid=1), next cycle 8'h5A, then tx_valid=0; fifo_cnt returns to 0; ovf=0.
- Captures 16'h0001, 16'h0002, 16'h0003 on consecutive cycles, tx_ready=1 -> byte stream 00,01,00,02,00,03 with no gap between words.
- Backpressure: tx_ready=0 for 5 cycles while in HI holding 16'h1234 -> tx_data stays 8'h12 and tx_valid stays 1; release -> 8'h12 then 8'h34.
- Overflow: tx_ready=0, we=1 for DEPTH+3=11 cycles with wd=0..10 -> 1 word in the serializer plus 8 in the FIFO; captures 9 and 10 dropped; ovf=1, drop_cnt=2; drained stream is words 0..8 in order.
- Full with simultaneous pop: fifo_cnt=8, serializer in LO; assert tx_ready and we=1 in the same cycle -> capture accepted, fifo_cnt stays 8, no drop. Then clr_ovf=1 -> ovf=0, drop_cnt=0. Then 300 drops -> drop_cnt saturates at 255.
- Reset asserted while in LO with 4 words queued -> next cycle tx_valid=0, fifo_cnt=0; a new capture 16'hBEEF then emits BE, EF only.
